pipelined_reduce_tree: RTL and testbench

PIPELINED_REDUCE_TREE -- requirements
Module: pipelined_reduce_tree

---
 rtl/pipelined_reduce_tree.sv | 162 ++++++++++++++++
 tb/tb_pipelined_reduce_tree.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_reduce_tree.sv
// pipelined_reduce_tree: BASE_FAN_IN-ary AND/OR/XOR reduction of QUANTITY
// words, one register stage per tree level, valid/ready at both ends.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   flush          synchronous clear of every in-flight operand set
//   in_valid/ready input handshake for op + din (QUANTITY words of WIDTH)
//   op             00 AND, 01 OR, 10 XOR, 11 reserved (result 0)
//   out_valid/ready output handshake for dout (WIDTH bits)
//   busy           any stage holds a valid entry
module pipelined_reduce_tree #(
    parameter int WIDTH       = 32,
    parameter int QUANTITY    = 8,
    parameter int BASE_FAN_IN = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic [WIDTH*QUANTITY-1:0] din,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          dout,
    output logic                      busy
);

    function automatic int calc_levels(input int q, input int b);
        int l;
        int p;
        l = 1;
        p = b;
        for (int i = 0; i < 8; i++) begin
            if (p < q) begin
                p = p * b;
                l = l + 1;
            end
        end
        return l;
    endfunction

    localparam int LEVELS = calc_levels(QUANTITY, BASE_FAN_IN);
    localparam int NLEAF  = BASE_FAN_IN ** LEVELS;

    function automatic logic [WIDTH-1:0] ident(input logic [1:0] o);
        return (o == 2'b00) ? '1 : '0;
    endfunction

    // Reserved op collapses every node to zero, so the result is zero too.
    function automatic logic [WIDTH-1:0] combine(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       o
    );
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] valid_d;
    logic [LEVELS-1:0] load;
    logic [LEVELS-1:0] en;

    // load[s]: stage s register may take new content this cycle, i.e. it is
    // empty or its current entry moves on. Computed as a running OR from the
    // output side so there is no combinational loop through a vector.
    always_comb begin
        logic go;
        go = out_ready;
        load = '0;
        for (int s = LEVELS - 1; s >= 0; s--) begin
            go = go || !valid_q[s];
            load[s] = go;
        end

        in_ready = load[0] && !flush && !rst;

        en = '0;
        valid_d = valid_q;
        en[0] = in_valid && in_ready;
        if (load[0]) begin
            valid_d[0] = en[0];
        end
        for (int s = 1; s < LEVELS; s++) begin
            en[s] = load[s] && valid_q[s-1];
            if (load[s]) begin
                valid_d[s] = valid_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Leaf lanes beyond QUANTITY carry the identity of the incoming op.
    logic [WIDTH-1:0] leaf [NLEAF];

    for (genvar k = 0; k < NLEAF; k++) begin : g_leaf
        if (k < QUANTITY) begin : g_din
            assign leaf[k] = din[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign leaf[k] = ident(op);
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NIN  = BASE_FAN_IN ** (LEVELS - l);
        localparam int NOUT = NIN / BASE_FAN_IN;

        logic [WIDTH-1:0] src [NIN];
        logic [1:0]       src_op;
        logic [WIDTH-1:0] data_d [NOUT];
        logic [WIDTH-1:0] data_q [NOUT];
        logic [1:0]       op_q;

        if (l == 0) begin : g_src
            assign src    = leaf;
            assign src_op = op;
        end else begin : g_src
            assign src    = g_lvl[l-1].data_q;
            assign src_op = g_lvl[l-1].op_q;
        end

        always_comb begin
            for (int j = 0; j < NOUT; j++) begin
                data_d[j] = ident(src_op);
                for (int i = 0; i < BASE_FAN_IN; i++) begin
                    data_d[j] = combine(data_d[j],
                                        src[j*BASE_FAN_IN+i],
                                        src_op);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '{default: '0};
                op_q   <= 2'b00;
            end else if (en[l]) begin
                data_q <= data_d;
                op_q   <= src_op;
            end
        end
    end

    assign dout      = g_lvl[LEVELS-1].data_q[0];
    assign out_valid = valid_q[LEVELS-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_pipelined_reduce_tree.sv
// tb_pipelined_reduce_tree: directed scoreboard bench for the reduce tree,
// main instance W=4/Q=8/B=3 plus Q=1,3,9,10 edge instances.
module tb_pipelined_reduce_tree;

    localparam int W  = 4;
    localparam int Q  = 8;
    localparam int LV = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     op;
    logic [W*Q-1:0] din;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   dout;
    logic           busy;

    pipelined_reduce_tree #(
        .WIDTH(W), .QUANTITY(Q), .BASE_FAN_IN(3)
    ) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .din(din),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .busy(busy)
    );

    // Edge configurations, WIDTH=8, share clk/rst/flush.
    logic        e_valid;
    logic [1:0]  e_op;
    logic [79:0] e_din;
    logic        e_ir   [4];
    logic        e_ov   [4];
    logic [7:0]  e_dout [4];
    logic        e_busy [4];

    pipelined_reduce_tree #(.WIDTH(8), .QUANTITY(1), .BASE_FAN_IN(3)) u_q1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(e_valid), .in_ready(e_ir[0]),
        .op(e_op), .din(e_din[7:0]),
        .out_valid(e_ov[0]), .out_ready(1'b1),
        .dout(e_dout[0]), .busy(e_busy[0])
    );
    pipelined_reduce_tree #(.WIDTH(8), .QUANTITY(3), .BASE_FAN_IN(3)) u_q3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(e_valid), .in_ready(e_ir[1]),
        .op(e_op), .din(e_din[23:0]),
        .out_valid(e_ov[1]), .out_ready(1'b1),
        .dout(e_dout[1]), .busy(e_busy[1])
    );
    pipelined_reduce_tree #(.WIDTH(8), .QUANTITY(9), .BASE_FAN_IN(3)) u_q9 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(e_valid), .in_ready(e_ir[2]),
        .op(e_op), .din(e_din[71:0]),
        .out_valid(e_ov[2]), .out_ready(1'b1),
        .dout(e_dout[2]), .busy(e_busy[2])
    );
    pipelined_reduce_tree #(.WIDTH(8), .QUANTITY(10), .BASE_FAN_IN(3)) u_q10 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(e_valid), .in_ready(e_ir[3]),
        .op(e_op), .din(e_din[79:0]),
        .out_valid(e_ov[3]), .out_ready(1'b1),
        .dout(e_dout[3]), .busy(e_busy[3])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_in  = 0;
    int   n_out = 0;
    bit   lat_chk = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o,
                                           input logic [W*Q-1:0] d);
        logic [W-1:0] r;
        r = (o == 2'b00) ? '1 : '0;
        for (int k = 0; k < Q; k++) begin
            case (o)
                2'b00:   r = r & d[k*W +: W];
                2'b01:   r = r | d[k*W +: W];
                2'b10:   r = r ^ d[k*W +: W];
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] gold(input logic [1:0] o,
                                        input logic [79:0] d,
                                        input int q);
        logic [7:0] r;
        r = (o == 2'b00) ? 8'hFF : 8'h00;
        for (int k = 0; k < q; k++) begin
            case (o)
                2'b00:   r = r & d[k*8 +: 8];
                2'b01:   r = r | d[k*8 +: 8];
                2'b10:   r = r ^ d[k*8 +: 8];
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    // One clock: handshakes are judged at the falling edge, inputs change
    // 1 time unit after the rising edge.
    task automatic tick();
        bit   t_in;
        bit   t_out;
        exp_t e;
        @(negedge clk);
        t_in  = in_valid && in_ready;
        t_out = out_valid && out_ready;
        if (t_out) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("dout", 32'(dout), 32'(e.d));
                if (lat_chk) check("latency", cyc - e.c, LV);
            end
        end
        if (t_in) begin
            n_in++;
            e.d = model(op, din);
            e.c = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    int q_tab   [4] = '{1, 3, 9, 10};
    int lat_tab [4] = '{1, 1, 2, 3};

    initial begin
        int n0;
        int base;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        op = 2'b00; din = '0; out_ready = 1'b1;
        e_valid = 1'b0; e_op = 2'b00; e_din = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // AND with a single cleared bit pattern in word 5
        lat_chk = 1'b1;
        op = 2'b00;
        din = {8{4'hF}};
        din[23:20] = 4'hB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("and_count", n_out, 1);

        // Back-to-back OR, XOR, AND
        in_valid = 1'b1;
        op = 2'b01; din = 32'h0000_0001;
        tick();
        op = 2'b10; din = {8{4'h3}};
        tick();
        op = 2'b00; din = {8{4'hF}};
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("b2b_count", n_out, 4);

        // Reserved op gives zero
        in_valid = 1'b1;
        op = 2'b11; din = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("rsv_count", n_out, 5);

        // Backpressure with continuous input
        lat_chk = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 2'b01;
        base = n_in;
        n0 = n_out;
        for (int i = 0; i < 5; i++) begin
            din = {28'd0, 4'(n_in - base + 1)};
            tick();
            if (i >= 1) check("bp_hold", 32'(dout), 32'd1);
        end
        check("bp_accepted", n_in - base, 2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (4) tick();
        check("bp_drained", n_out - n0, 2);
        check("bp_queue", exp_q.size(), 0);

        // Flush with two entries held by backpressure
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 2'b01;
        din = 32'h5;
        tick();
        din = 32'h6;
        tick();
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        n0 = n_out;
        repeat (4) tick();
        check("flush_no_ghost", n_out, n0);

        // Flush coinciding with an output transfer
        lat_chk = 1'b1;
        in_valid = 1'b1;
        din = 32'h7;
        tick();
        din = 32'h8;
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        n0 = n_out;
        tick();
        flush = 1'b0;
        check("flushx_consumed", n_out - n0, 1);
        exp_q.delete();
        check("flushx_out_valid", 32'(out_valid), 32'd0);
        check("flushx_busy", 32'(busy), 32'd0);
        n0 = n_out;
        repeat (4) tick();
        check("flushx_no_ghost", n_out, n0);

        // Reset mid-stream
        in_valid = 1'b1;
        din = 32'h9;
        tick();
        din = 32'hA;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_dout", 32'(dout), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        n0 = n_out;
        repeat (4) tick();
        check("rst2_no_ghost", n_out, n0);

        // Edge configurations with random op/din
        for (int t = 0; t < 8; t++) begin
            e_op  = 2'($urandom_range(0, 3));
            e_din = {$urandom(), $urandom(), 16'($urandom())};
            e_valid = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                check($sformatf("e_in_ready_q%0d", q_tab[d]),
                      32'(e_ir[d]), 32'd1);
            end
            @(posedge clk);
            #1;
            e_valid = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++) begin
                    check($sformatf("e_valid_q%0d_c%0d", q_tab[d], k),
                          32'(e_ov[d]), 32'(k == lat_tab[d]));
                    if (k == lat_tab[d]) begin
                        check($sformatf("e_dout_q%0d", q_tab[d]),
                              32'(e_dout[d]),
                              32'(gold(e_op, e_din, q_tab[d])));
                    end
                end
                @(posedge clk);
                #1;
            end
        end

        check("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
